isr_sequencer: RTL and testbench
================================

Name: isr_sequencer

Overview:
- Interrupt controller that sequences the special-purpose register file.
- Collects internal exception events and external interrupt lines, and applies the status-register mask.
- Produces a registered jisr/mca/rpt bundle for the SPR file, together with the interrupt level for the handler-address logic.
- Owns the post-jisr drain window (pipeline flush) and the power-on reset interrupt.

Parameters:
- N_CAUSE, 23, width of the cause/mca vector. Fixed; other values are unsupported.
- N_EXT, 16, number of external interrupt lines, mapped to cause bits 7..22.
- DRAIN_CYCLES, 2, number of stall cycles after a jisr pulse before events are accepted again. Legal range 1..7.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  an instruction completes this cycle; qualifies all ev_* internal events.
- ev_ill  in  1  illegal instruction (cause 1).
- ev_mal  in  1  misaligned access (cause 2).
- ev_pff  in  1  page fault on fetch (cause 3).
- ev_pfls  in  1  page fault on load/store (cause 4).
- ev_trap  in  1  trap/syscall (cause 5).
- ev_ovf  in  1  arithmetic overflow (cause 6, maskable).
- ev_ext  in  N_EXT  external interrupt request lines, already synchronous to clk.
- sr  in  N_CAUSE  status register from the SPR file; bit i enables cause i for i>=6; bits 0..5 are ignored.
- jisr  out  1  one-cycle pulse: take the interrupt.
- rpt  out  1  valid with jisr: 1 = repeat the faulting instruction, 0 = continue.
- mca  out  N_CAUSE  masked cause vector, valid with jisr.
- il  out  5  index of the lowest set mca bit, valid with jisr.
- ext_ack  out  N_EXT  one-hot pulse with jisr: the external line being serviced.
- stall  out  1  high while not in RUN; the fetch stage holds.

Behaviour:
- States: RST_INT, RUN, DRAIN. The state register and a 3-bit drain counter are the only sequencing state.

Reset:
- While reset=1: state=RST_INT, pend=0, drain counter=0.
- Outputs during reset: jisr=0, rpt=0, mca=0, il=0, ext_ack=0, stall=1.

RST_INT:
- In the first cycle after reset falls, the block leaves RST_INT.
- Registered outputs in the following cycle: jisr=1, mca=23'h1, il=0, rpt=0, then the block enters DRAIN.

Pending latch (pend[22:7]):
- pend |= ev_ext every cycle in every state except reset.
- The bit for an acknowledged line clears in the same edge that raises ext_ack.
- A line still high after ack re-sets pend on the next cycle.

Cause and mask:
- ca = {pend, ev_ovf, ev_trap, ev_pfls, ev_pff, ev_mal, ev_ill, 1'b0}.
- Internal bits 1..6 are forced to 0 unless instr_valid=1.
- mca_c[i] = ca[i] for i<=5; mca_c[i] = ca[i] & sr[i] for i>=6.

RUN:
- If |mca_c, then at the next edge: jisr=1, mca=mca_c, il=lowest set index, rpt=(il==3 || il==4).
- If il>=7, ext_ack[il-7]=1.
- Drain counter loads DRAIN_CYCLES-1; next state DRAIN.
- Latency is exactly 1 cycle from event to jisr. stall=0 in RUN.

DRAIN:
- jisr, mca, il, rpt and ext_ack return to 0 after the pulse cycle; stall=1.
- Internal events are discarded; external lines still latch into pend.
- The counter decrements each cycle. At 0 the state goes to RUN, with stall low in that same RUN cycle.
- Total stall length is DRAIN_CYCLES+1 cycles, counting the jisr cycle.

Priority and simultaneous events:
- Priority is lowest index first.
- Simultaneous internal and external causes: all appear in mca, only il is prioritised.
- An unacked pending external line stays latched and fires after DRAIN if still unmasked.

Masking:
- sr is sampled combinationally in RUN only.
- A masked pending line stays pending indefinitely, with no ack and no loss.

Reset mid-operation:
- Reset in DRAIN or RUN aborts everything, clears pend, and replays the RST_INT sequence.

Decomposition:
- Shared package isr_pkg holds:
  - cause indices CA_RESET=0 .. CA_OVF=6, CA_EXT0=7;
  - N_CAUSE;
  - state encodings RST_INT/RUN/DRAIN;
  - the repeat-cause set {3,4}.
- One sub-module: prio_enc_lsb (N_CAUSE-in, 5-bit index plus any-valid out, purely combinational). It is reused by the SPR read-mux decode and by the handler-address logic.

Test Plan:
- Reset: hold reset 3 cycles, release -> the next cycle has jisr=1, mca=23'h000001, il=0, rpt=0, then stall=1 for DRAIN_CYCLES more cycles.
- Illegal instruction: ev_ill=1 with instr_valid=1 in RUN -> the next cycle has jisr=1, mca=23'h000002, il=1, rpt=0; the same ev_ill during DRAIN gives no jisr.
- Page fault with overflow: ev_pff=1, ev_ovf=1, sr=23'h000040, instr_valid=1 -> mca=23'h000048, il=3, rpt=1.
- Masked external: ev_ext[2] pulsed 1 cycle with sr[9]=0 -> no jisr for 20 cycles. Then set sr[9]=1 -> jisr with mca=23'h000200, il=9, ext_ack=16'h0004, and pend[9] cleared.
- Multiple externals: ev_ext=16'h0003 held high during DRAIN with sr=23'h7FFF80 -> the first RUN gives jisr, il=7, ext_ack=16'h0001. The following sequence repeats with il=8, ext_ack=16'h0002; line 0 is still high, so it re-pends.
- Reset mid-DRAIN: assert reset in the 2nd DRAIN cycle -> pend=0 and outputs are 0. After release the bench sees the reset interrupt (mca=23'h1), not the prior cause.

Source files
------------

// File: rtl/isr_pkg.sv
// rtl/isr_pkg.sv - shared cause indices, state encoding and repeat-cause helper for the interrupt sequencer
package isr_pkg;

  localparam int N_CAUSE = 23;

  localparam int CA_RESET = 0;
  localparam int CA_ILL   = 1;
  localparam int CA_MAL   = 2;
  localparam int CA_PFF   = 3;
  localparam int CA_PFLS  = 4;
  localparam int CA_TRAP  = 5;
  localparam int CA_OVF   = 6;
  localparam int CA_EXT0  = 7;

  typedef enum logic [1:0] {
    RST_INT = 2'd0,
    RUN     = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  // Page faults re-execute the faulting instruction; every other cause continues.
  function automatic logic is_repeat(input logic [4:0] idx);
    return (idx == 5'(CA_PFF)) || (idx == 5'(CA_PFLS));
  endfunction

endpackage

// File: rtl/prio_enc_lsb.sv
// rtl/prio_enc_lsb.sv - combinational lowest-set-bit priority encoder
module prio_enc_lsb #(
  parameter int N = 23
) (
  input  logic [N-1:0] vec,
  output logic [4:0]   idx,
  output logic         any
);

  // Scan high to low so the lowest set bit is the last assignment to win.
  always_comb begin
    idx = '0;
    any = |vec;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
  end

endmodule

// File: rtl/isr_sequencer.sv
// rtl/isr_sequencer.sv - interrupt sequencer driving the jisr/mca/rpt bundle and post-jisr drain
module isr_sequencer
  import isr_pkg::state_t, isr_pkg::RST_INT, isr_pkg::RUN, isr_pkg::DRAIN,
         isr_pkg::CA_OVF, isr_pkg::CA_EXT0, isr_pkg::is_repeat;
#(
  parameter int N_CAUSE      = isr_pkg::N_CAUSE,
  parameter int N_EXT        = 16,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic               ev_ill,
  input  logic               ev_mal,
  input  logic               ev_pff,
  input  logic               ev_pfls,
  input  logic               ev_trap,
  input  logic               ev_ovf,
  input  logic [N_EXT-1:0]   ev_ext,
  input  logic [N_CAUSE-1:0] sr,
  output logic               jisr,
  output logic               rpt,
  output logic [N_CAUSE-1:0] mca,
  output logic [4:0]         il,
  output logic [N_EXT-1:0]   ext_ack,
  output logic               stall
);

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);
  localparam logic [N_CAUSE-1:0] ALWAYS_EN = {{(N_CAUSE - CA_OVF){1'b0}}, {CA_OVF{1'b1}}};

  state_t             state;
  logic [2:0]         drain_cnt;
  logic [N_EXT-1:0]   pend;

  logic [5:0]         int_ev;
  logic [N_CAUSE-1:0] ca;
  logic [N_CAUSE-1:0] mca_c;
  logic [4:0]         il_c;
  logic               any_c;
  logic               fire;
  logic [N_EXT-1:0]   ack_c;

  always_comb begin
    int_ev = {ev_ovf, ev_trap, ev_pfls, ev_pff, ev_mal, ev_ill} & {6{instr_valid}};
    ca     = {pend, int_ev, 1'b0};
    mca_c  = ca & (sr | ALWAYS_EN);
  end

  prio_enc_lsb #(.N(N_CAUSE)) u_prio (
    .vec (mca_c),
    .idx (il_c),
    .any (any_c)
  );

  always_comb begin
    fire  = (state == RUN) && any_c;
    ack_c = '0;
    if (fire && (il_c >= 5'(CA_EXT0)))
      ack_c = {{(N_EXT - 1){1'b0}}, 1'b1} << (il_c - 5'(CA_EXT0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RST_INT;
      drain_cnt <= '0;
      pend      <= '0;
      jisr      <= 1'b0;
      rpt       <= 1'b0;
      mca       <= '0;
      il        <= '0;
      ext_ack   <= '0;
      stall     <= 1'b1;
    end else begin
      // The serviced line is dropped on the ack edge even if still asserted; it re-latches next cycle.
      pend    <= (pend | ev_ext) & ~ack_c;
      jisr    <= 1'b0;
      rpt     <= 1'b0;
      mca     <= '0;
      il      <= '0;
      ext_ack <= '0;
      case (state)
        RST_INT: begin
          jisr      <= 1'b1;
          mca       <= {{(N_CAUSE - 1){1'b0}}, 1'b1};
          state     <= DRAIN;
          drain_cnt <= DRAIN_LOAD;
          stall     <= 1'b1;
        end
        RUN: begin
          if (fire) begin
            jisr      <= 1'b1;
            mca       <= mca_c;
            il        <= il_c;
            rpt       <= is_repeat(il_c);
            ext_ack   <= ack_c;
            state     <= DRAIN;
            drain_cnt <= DRAIN_LOAD;
            stall     <= 1'b1;
          end else begin
            stall <= 1'b0;
          end
        end
        DRAIN: begin
          // The pulse cycle itself does not count down, giving DRAIN_CYCLES+1 stalled cycles in total.
          if (!jisr) begin
            if (drain_cnt == 3'd0) begin
              state <= RUN;
              stall <= 1'b0;
            end else begin
              drain_cnt <= drain_cnt - 3'd1;
            end
          end
        end
        default: begin
          state <= RST_INT;
          stall <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_isr_sequencer.sv
// tb/tb_isr_sequencer.sv - directed scoreboard bench for isr_sequencer
module tb_isr_sequencer;

  localparam int DRAIN_N = 2;

  typedef struct packed {
    logic [22:0] mca;
    logic [4:0]  il;
    logic        rpt;
    logic [15:0] ack;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        ev_ill, ev_mal, ev_pff, ev_pfls, ev_trap, ev_ovf;
  logic [15:0] ev_ext;
  logic [22:0] sr;
  logic        jisr, rpt, stall;
  logic [22:0] mca;
  logic [4:0]  il;
  logic [15:0] ext_ack;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  isr_sequencer #(.N_CAUSE(23), .N_EXT(16), .DRAIN_CYCLES(DRAIN_N)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .ev_ill      (ev_ill),
    .ev_mal      (ev_mal),
    .ev_pff      (ev_pff),
    .ev_pfls     (ev_pfls),
    .ev_trap     (ev_trap),
    .ev_ovf      (ev_ovf),
    .ev_ext      (ev_ext),
    .sr          (sr),
    .jisr        (jisr),
    .rpt         (rpt),
    .mca         (mca),
    .il          (il),
    .ext_ack     (ext_ack),
    .stall       (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic push(input logic [22:0] m, input logic [4:0] i, input logic r, input logic [15:0] a);
    exp_t e;
    e.mca = m; e.il = i; e.rpt = r; e.ack = a;
    sb.push_back(e);
  endtask

  // Waits (bounded) for a jisr pulse and compares the bundle against the oldest expectation.
  task automatic expect_jisr(input string tag, input int budget);
    exp_t e;
    int   n = 0;
    while (jisr !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_jisr"}, {31'd0, jisr}, 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_mca"}, {9'd0, mca}, {9'd0, e.mca});
      check({tag, "_il"}, {27'd0, il}, {27'd0, e.il});
      check({tag, "_rpt"}, {31'd0, rpt}, {31'd0, e.rpt});
      check({tag, "_ack"}, {16'd0, ext_ack}, {16'd0, e.ack});
    end
  endtask

  task automatic drain_check(input string tag);
    for (int k = 0; k < DRAIN_N; k++) begin
      @(negedge clk);
      check({tag, "_stall"}, {31'd0, stall}, 32'd1);
      check({tag, "_nojisr"}, {31'd0, jisr}, 32'd0);
    end
    @(negedge clk);
    check({tag, "_run"}, {31'd0, stall}, 32'd0);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int hits = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (jisr === 1'b1) hits++;
    end
    check({tag, "_quiet"}, hits, 32'd0);
  endtask

  task automatic clear_int();
    instr_valid = 1'b0;
    ev_ill = 1'b0; ev_mal = 1'b0; ev_pff = 1'b0;
    ev_pfls = 1'b0; ev_trap = 1'b0; ev_ovf = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_int();
    ev_ext = '0;
    sr = '0;

    repeat (3) @(negedge clk);
    check("rst_jisr", {31'd0, jisr}, 32'd0);
    check("rst_mca", {9'd0, mca}, 32'd0);
    check("rst_il", {27'd0, il}, 32'd0);
    check("rst_rpt", {31'd0, rpt}, 32'd0);
    check("rst_ack", {16'd0, ext_ack}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd1);

    push(23'h000001, 5'd0, 1'b0, 16'h0000);
    reset = 1'b0;
    expect_jisr("por", 1);
    drain_check("por");

    // Illegal instruction; held through DRAIN must not retrigger.
    instr_valid = 1'b1; ev_ill = 1'b1;
    push(23'h000002, 5'd1, 1'b0, 16'h0000);
    expect_jisr("ill", 1);
    drain_check("ill_drain");
    instr_valid = 1'b0;
    quiet("ill_novalid", 2);
    clear_int();

    // Masked overflow alone must not fire.
    instr_valid = 1'b1; ev_ovf = 1'b1; sr = 23'h000000;
    quiet("ovf_masked", 1);

    instr_valid = 1'b1; ev_pff = 1'b1; ev_ovf = 1'b1; sr = 23'h000040;
    push(23'h000048, 5'd3, 1'b1, 16'h0000);
    expect_jisr("pff_ovf", 1);
    clear_int();
    drain_check("pff_drain");

    // Masked external stays pending until enabled.
    sr = 23'h000000;
    ev_ext = 16'h0004;
    @(negedge clk);
    ev_ext = 16'h0000;
    quiet("ext_masked", 20);
    sr = 23'h000200;
    push(23'h000200, 5'd9, 1'b0, 16'h0004);
    expect_jisr("ext9", 1);
    drain_check("ext9_drain");
    quiet("ext9_cleared", 3);

    // Two externals latched during DRAIN.
    sr = 23'h7FFF80;
    instr_valid = 1'b1; ev_trap = 1'b1;
    push(23'h000020, 5'd5, 1'b0, 16'h0000);
    expect_jisr("trap", 1);
    clear_int();
    ev_ext = 16'h0003;
    drain_check("trap_drain");
    push(23'h000180, 5'd7, 1'b0, 16'h0001);
    expect_jisr("ext7", 1);
    ev_ext = 16'h0000;
    drain_check("ext7_drain");
    push(23'h000100, 5'd8, 1'b0, 16'h0002);
    expect_jisr("ext8", 1);
    drain_check("ext8_drain");

    // Internal and external together; external fires after DRAIN.
    ev_ext = 16'h0008;
    @(negedge clk);
    ev_ext = 16'h0000;
    instr_valid = 1'b1; ev_mal = 1'b1;
    push(23'h000404, 5'd2, 1'b0, 16'h0000);
    expect_jisr("mal_ext", 1);
    clear_int();
    drain_check("mal_drain");
    push(23'h000400, 5'd10, 1'b0, 16'h0008);
    expect_jisr("ext10", 1);
    drain_check("ext10_drain");

    // A line held high through its ack re-pends and fires again.
    ev_ext = 16'h0001;
    push(23'h000080, 5'd7, 1'b0, 16'h0001);
    expect_jisr("hold1", 2);
    drain_check("hold1_drain");
    push(23'h000080, 5'd7, 1'b0, 16'h0001);
    expect_jisr("hold2", 1);
    ev_ext = 16'h0000;
    drain_check("hold2_drain");
    quiet("hold_done", 3);

    // Reset in the second DRAIN cycle discards the pending external.
    instr_valid = 1'b1; ev_ill = 1'b1;
    push(23'h000002, 5'd1, 1'b0, 16'h0000);
    expect_jisr("pre_rst", 1);
    clear_int();
    ev_ext = 16'h0010;
    @(negedge clk);
    reset = 1'b1;
    ev_ext = 16'h0000;
    @(negedge clk);
    check("mid_rst_jisr", {31'd0, jisr}, 32'd0);
    check("mid_rst_mca", {9'd0, mca}, 32'd0);
    check("mid_rst_ack", {16'd0, ext_ack}, 32'd0);
    check("mid_rst_stall", {31'd0, stall}, 32'd1);
    check("mid_rst_pend", {16'd0, dut.pend}, 32'd0);
    push(23'h000001, 5'd0, 1'b0, 16'h0000);
    reset = 1'b0;
    expect_jisr("por2", 1);
    drain_check("por2_drain");
    quiet("por2_nopend", 4);

    check("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
